// File: rtl/mp3_dct_pkg.sv
// mp3_dct_pkg
// Shared definitions for the 4-point DCT-II / DCT-III (IDCT) datapaths.
// Contents:
//   FRAC_BITS, Q_ONE : Q1.14 fixed-point format of the transform constants
//   CW               : width of one transform constant
//   DCT2_C[k][n]     : forward DCT-II constants, cos(pi/4*k*(n+0.5)) in Q1.14
//   IDCT_C[k][n]     : inverse constants, 0.5*w_k*cos(pi/4*k*(n+0.5)) in Q1.14
//                      with w_0 = 0.5 and w_k = 1 otherwise
//   state_t          : sequencing state of the serial MAC transform blocks
// All constants are truncated toward zero.
package mp3_dct_pkg;

  localparam int FRAC_BITS = 14;
  localparam int Q_ONE     = 16384;
  localparam int CW        = 16;

  // Forward table: row k is the k-th cosine basis sampled at n = 0..3.
  localparam logic signed [CW-1:0] DCT2_C [4][4] = '{
    '{ 16'sd16384,  16'sd16384,  16'sd16384,  16'sd16384},
    '{ 16'sd15136,  16'sd6269,  -16'sd6269,  -16'sd15136},
    '{ 16'sd11585, -16'sd11585, -16'sd11585,  16'sd11585},
    '{ 16'sd6269,  -16'sd15136,  16'sd15136, -16'sd6269 }
  };

  // Inverse table: row k holds the weight of X[k] in each output sample x[n].
  // The DC row carries the extra 0.5 so the pair is an exact inverse.
  localparam logic signed [CW-1:0] IDCT_C [4][4] = '{
    '{ 16'sd4096,  16'sd4096,  16'sd4096,  16'sd4096},
    '{ 16'sd7568,  16'sd3134, -16'sd3134, -16'sd7568},
    '{ 16'sd5792, -16'sd5792, -16'sd5792,  16'sd5792},
    '{ 16'sd3134, -16'sd7568,  16'sd7568, -16'sd3134}
  };

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } state_t;

endpackage

// File: rtl/mp3_round_sat.sv
// mp3_round_sat
// Combinational conversion of a wide fixed-point accumulator to a DW-bit
// sample: round half up at FRAC_BITS, then clamp to the signed DW range.
// Ports:
//   acc    in  AW  signed accumulator with FRAC_BITS fractional bits
//   sample out DW  signed rounded and saturated integer sample
module mp3_round_sat #(
  parameter int AW        = 32,
  parameter int DW        = 16,
  parameter int FRAC_BITS = 14
) (
  input  logic signed [AW-1:0] acc,
  output logic signed [DW-1:0] sample
);

  // One guard bit on top so the rounding add can never wrap.
  localparam logic signed [AW:0] HALF    = {{(AW-FRAC_BITS+1){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [AW:0] SAT_MAX = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW:0] sum;
  logic signed [AW:0] shifted;

  always_comb begin
    sum     = $signed({acc[AW-1], acc}) + HALF;
    // Arithmetic shift floors, so the add above gives round-half-up.
    shifted = sum >>> FRAC_BITS;
    if (shifted > SAT_MAX) begin
      sample = SAT_MAX[DW-1:0];
    end else if (shifted < SAT_MIN) begin
      sample = SAT_MIN[DW-1:0];
    end else begin
      sample = shifted[DW-1:0];
    end
  end

endmodule

// File: rtl/idct_t3.sv
// idct_t3
// Serial 4-point inverse DCT (DCT-III). One coefficient group is accepted
// per handshake. The block spends four cycles multiplying one coefficient
// by a table row into four parallel accumulators, then one cycle rounding
// and saturating. It holds the samples until the output handshake.
// Ports:
//   clk                       in   clock
//   reset                     in   synchronous active-high reset
//   coef0..coef3              in   DW signed spectral inputs X[0..3]
//   in_valid / in_ready       in/out input handshake (ready only when idle)
//   out_sample0..out_sample3  out  DW signed reconstructed samples x[0..3]
//   out_valid / out_ready     out/in output handshake
module idct_t3 #(
  parameter int DW        = 16,
  parameter int FRAC_BITS = 14,
  parameter int AW        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] coef0,
  input  logic signed [DW-1:0] coef1,
  input  logic signed [DW-1:0] coef2,
  input  logic signed [DW-1:0] coef3,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] out_sample0,
  output logic signed [DW-1:0] out_sample1,
  output logic signed [DW-1:0] out_sample2,
  output logic signed [DW-1:0] out_sample3,
  output logic                 out_valid,
  input  logic                 out_ready
);

  import mp3_dct_pkg::*;

  localparam int PW = DW + CW;

  state_t               state;
  state_t               state_next;
  logic [1:0]           k_cnt;
  logic signed [DW-1:0] coef_reg   [4];
  logic signed [DW-1:0] coef_sel;
  logic signed [PW-1:0] prod       [4];
  logic signed [AW-1:0] acc        [4];
  logic signed [DW-1:0] rounded    [4];
  logic signed [DW-1:0] sample_reg [4];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake flags. Both flags depend only on the state
  // register, so neither valid nor ready has a combinational input path.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = MAC;
        end
      end
      MAC: begin
        if (k_cnt == 2'd3) begin
          state_next = ROUND;
        end
      end
      ROUND: begin
        state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One coefficient is broadcast per cycle against row k of the table,
  // giving that coefficient's contribution to all four samples at once.
  always_comb begin
    coef_sel = coef_reg[k_cnt];
    for (int n = 0; n < 4; n++) begin
      prod[n] = PW'(coef_sel) * PW'(IDCT_C[k_cnt][n]);
    end
  end

  // Datapath: latch on accept, accumulate during MAC (k=0 loads so no
  // explicit clear is needed between groups), capture samples in ROUND.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_cnt <= 2'd0;
      for (int n = 0; n < 4; n++) begin
        coef_reg[n]   <= '0;
        acc[n]        <= '0;
        sample_reg[n] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            coef_reg[0] <= coef0;
            coef_reg[1] <= coef1;
            coef_reg[2] <= coef2;
            coef_reg[3] <= coef3;
            k_cnt       <= 2'd0;
          end
        end
        MAC: begin
          for (int n = 0; n < 4; n++) begin
            if (k_cnt == 2'd0) begin
              acc[n] <= AW'(prod[n]);
            end else begin
              acc[n] <= acc[n] + AW'(prod[n]);
            end
          end
          k_cnt <= k_cnt + 2'd1;
        end
        ROUND: begin
          for (int n = 0; n < 4; n++) begin
            sample_reg[n] <= rounded[n];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // One rounding/saturation slice per output sample.
  for (genvar g = 0; g < 4; g++) begin : g_round
    mp3_round_sat #(
      .AW        (AW),
      .DW        (DW),
      .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
      .acc    (acc[g]),
      .sample (rounded[g])
    );
  end

  assign out_sample0 = sample_reg[0];
  assign out_sample1 = sample_reg[1];
  assign out_sample2 = sample_reg[2];
  assign out_sample3 = sample_reg[3];

endmodule

// File: tb/tb_idct_t3.sv
// tb_idct_t3
// Self-checking bench for idct_t3: directed vectors plus randomized groups,
// compared against a plain-arithmetic model of x[n] = sum_k C[k][n]*X[k]
// with round-half-up and saturation to 16 bits.
module tb_idct_t3;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] coef0, coef1, coef2, coef3;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] out_sample0, out_sample1, out_sample2, out_sample3;
  logic                 out_valid;
  logic                 out_ready;

  int checks = 0;
  int errors = 0;
  int cur_x [4];
  int lat;

  // Inverse transform weights, 0.5*w_k*cos(pi/4*k*(n+0.5)) in Q1.14.
  int c_tab [4][4] = '{
    '{4096,  4096,  4096,  4096},
    '{7568,  3134, -3134, -7568},
    '{5792, -5792, -5792,  5792},
    '{3134, -7568,  7568, -3134}
  };

  always #5 clk = ~clk;

  idct_t3 dut (
    .clk         (clk),
    .reset       (reset),
    .coef0       (coef0),
    .coef1       (coef1),
    .coef2       (coef2),
    .coef3       (coef3),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_sample0 (out_sample0),
    .out_sample1 (out_sample1),
    .out_sample2 (out_sample2),
    .out_sample3 (out_sample3),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Reference: exact integer sum, floor((s + 2^13) / 2^14), clamp.
  function automatic int modelSample(input int n);
    longint s;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      s += longint'(cur_x[k]) * longint'(c_tab[k][n]);
    end
    s = (s + 64'sd8192) >>> 14;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  function automatic logic signed [DW-1:0] sampleOf(input int n);
    case (n)
      0:       return out_sample0;
      1:       return out_sample1;
      2:       return out_sample2;
      default: return out_sample3;
    endcase
  endfunction

  task automatic checkSamples(input string tag);
    for (int n = 0; n < 4; n++) begin
      checkOutput($sformatf("%s_x%0d", tag, n), sampleOf(n), modelSample(n));
    end
  endtask

  // Called at a falling edge. Offers a group, waits for acceptance, then
  // counts rising edges until out_valid; returns at a falling edge.
  task automatic applyStimulus(input int x0, input int x1, input int x2, input int x3,
                               output int edges);
    int waited;
    waited   = 0;
    cur_x    = '{x0, x1, x2, x3};
    coef0    = 16'(x0);
    coef1    = 16'(x1);
    coef2    = 16'(x2);
    coef3    = 16'(x3);
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 0, 1);
      in_valid = 1'b0;
      edges    = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    edges    = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  // Holds out_ready low for 'stall' cycles (samples must stay put), then
  // completes the output handshake and checks the block is idle again.
  task automatic releaseOutput(input int stall);
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_in_ready", in_ready, 0);
        checkSamples("hold");
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_out_valid", out_valid, 0);
    checkOutput("post_in_ready", in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int exp_k1 [4];
    int rx [4];
    int stall;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    coef0     = '0;
    coef1     = '0;
    coef2     = '0;
    coef3     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    for (int n = 0; n < 4; n++) checkOutput("rst_sample", sampleOf(n), 0);

    // DC basis and exact latency.
    applyStimulus(16384, 0, 0, 0, lat);
    checkOutput("dc_latency", lat, 5);
    for (int n = 0; n < 4; n++) checkOutput("dc_sample", sampleOf(n), 4096);
    releaseOutput(0);

    // k1 basis.
    exp_k1 = '{7568, 3134, -3134, -7568};
    applyStimulus(0, 16384, 0, 0, lat);
    checkOutput("k1_latency", lat, 5);
    for (int n = 0; n < 4; n++) checkOutput("k1_sample", sampleOf(n), exp_k1[n]);
    releaseOutput(0);

    // Round trip of a constant 1000.
    applyStimulus(4000, 0, 0, 0, lat);
    for (int n = 0; n < 4; n++) checkOutput("rt_sample", sampleOf(n), 1000);
    releaseOutput(0);

    // Positive and negative saturation.
    applyStimulus(32767, 32767, 32767, 32767, lat);
    checkOutput("satp_x0", out_sample0, 32767);
    checkOutput("satp_x1", out_sample1, -12260);
    checkSamples("satp");
    releaseOutput(0);
    applyStimulus(-32767, -32767, -32767, -32767, lat);
    checkOutput("satn_x0", out_sample0, -32768);
    checkSamples("satn");
    releaseOutput(1);

    // Backpressure with a second group waiting at the input.
    out_ready = 1'b0;
    applyStimulus(1000, -2000, 3000, -4000, lat);
    checkOutput("bp_latency", lat, 5);
    coef0    = 16'sd500;
    coef1    = 16'sd600;
    coef2    = -16'sd700;
    coef3    = 16'sd800;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_in_ready", in_ready, 0);
      checkSamples("bp_first");
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_done_valid", out_valid, 0);
    checkOutput("bp_done_ready", in_ready, 1);
    applyStimulus(500, 600, -700, 800, lat);
    checkOutput("bp2_latency", lat, 5);
    checkSamples("bp_second");
    releaseOutput(0);

    // Reset sampled at E2, during MAC.
    cur_x    = '{20000, 10000, -5000, 7000};
    coef0    = 16'sd20000;
    coef1    = 16'sd10000;
    coef2    = -16'sd5000;
    coef3    = 16'sd7000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rmac_out_valid", out_valid, 0);
    checkOutput("rmac_in_ready", in_ready, 1);
    for (int n = 0; n < 4; n++) checkOutput("rmac_sample", sampleOf(n), 0);
    applyStimulus(16384, 0, 0, 0, lat);
    checkOutput("rmac_dc_latency", lat, 5);
    for (int n = 0; n < 4; n++) checkOutput("rmac_dc", sampleOf(n), 4096);
    releaseOutput(0);

    // Reset while stalled in OUT.
    out_ready = 1'b0;
    applyStimulus(-9000, 1234, 4321, -777, lat);
    checkSamples("rout_pre");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    checkOutput("rout_out_valid", out_valid, 0);
    checkOutput("rout_in_ready", in_ready, 1);
    for (int n = 0; n < 4; n++) checkOutput("rout_sample", sampleOf(n), 0);

    // Randomized groups with occasional full-scale values and short stalls.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++) begin
        rx[k] = int'($urandom_range(0, 65535)) - 32768;
        if ($urandom_range(0, 7) == 0) rx[k] = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
      end
      stall = int'($urandom_range(0, 2));
      applyStimulus(rx[0], rx[1], rx[2], rx[3], lat);
      checkOutput("rand_latency", lat, 5);
      checkSamples("rand");
      releaseOutput(stall);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idct_t3.md
# idct_t3

Four-point inverse DCT (DCT-III), the synthesis-side counterpart of the team's serial 4-point DCT-II MAC block. It accepts one group of four Q-domain coefficients through a valid/ready handshake. It accumulates the inverse transform serially, one coefficient per cycle, into four parallel accumulators, then rounds and saturates the results. It presents four time-domain samples behind a valid/ready handshake. The block sits between the requantizer/subband stage and PCM reconstruction.

## Interface
Parameters:
- `DW`, 16, width of the input coefficients and output samples (signed).
- `FRAC_BITS`, 14, number of fractional bits in the Q1.14 transform constants.
- `AW`, 32, accumulator width (signed).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `coef0..coef3`  in  DW  signed spectral inputs X[0..3]; sampled on input handshake.
- `in_valid`  in  1  input group valid.
- `in_ready`  out  1  block can accept a group.
- `out_sample0..out_sample3`  out  DW  signed reconstructed samples x[0..3].
- `out_valid`  out  1  output samples valid.
- `out_ready`  in  1  downstream accepts the output samples.

## Operation
- Transform: x[n] = Σk C[k][n]·X[k], with C[k][n] = 0.5·w_k·cos(π/4·k·(n+0.5)), where w_0 = 0.5 and w_k = 1 otherwise. This is the exact inverse of the unnormalized DCT-II.
- Q1.14 constants are truncated toward zero:
  - k0: 4096, 4096, 4096, 4096
  - k1: 7568, 3134, −3134, −7568
  - k2: 5792, −5792, −5792, 5792
  - k3: 3134, −7568, 7568, −3134
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid`, latch coef0..3, set k=0, go to MAC.
  - MAC: each cycle acc[n] += X[k]·C[k][n] for all four n. On k=0, load the product instead of accumulating. k increments each cycle. After k=3, go to ROUND.
  - ROUND: out_sample[n] = sat_DW((acc[n] + 2^(FRAC_BITS−1)) >>> FRAC_BITS). Set `out_valid`=1, go to OUT.
  - OUT: hold until `out_ready`, then clear `out_valid` and go to IDLE.
- `in_ready` is 1 only in IDLE. `in_valid` is ignored in every other state.
- Arithmetic: DW×DW signed products, sign-extended to AW. The worst-case |acc| is below 2^31, so there is no accumulator overflow.
- Rounding is round-half-up (add, then arithmetic shift). Saturation clamps to [−32768, 32767].
- `out_sample*` are stable from ROUND until the next ROUND. They stay stable while `out_valid`=1 and `out_ready`=0.
- Reset, including reset mid-MAC or mid-OUT:
  - state goes to IDLE, accumulators clear, and the current group is discarded;
  - `out_sample*`=0, `out_valid`=0, `in_ready`=1 in the first cycle after reset.

## Timing
- Call the input-handshake edge E0.
- MAC occupies edges E1–E4 (k=0..3).
- ROUND occurs at E5, so `out_valid`=1 in the cycle following E5.
- Latency from input handshake to `out_valid` is 5 clocks.
- With `out_ready` held at 1, the output handshake occurs at E6, `in_ready`=1 after E6, and the next accept is at E7. Peak throughput is one group per 7 cycles.
- Backpressure stretches the OUT state without limit. No data is lost.
- `in_ready` and `out_valid` are registered state decodes; there are no combinational paths from `in_valid` or `out_ready`.

## Structure
- Shared package `mp3_dct_pkg` holds:
  - the constants FRAC_BITS and Q_ONE=16384;
  - the 4×4 Q1.14 IDCT constant table (C[k][n]), next to the forward DCT-II table;
  - the FSM state typedef (IDLE/MAC/ROUND/OUT).
- Sub-module `mp3_round_sat`: combinational AW→DW round-half-up and saturate. Instantiate it four times; it is reusable by the forward DCT path.

## Test plan
- Single-coefficient DC: X=(16384,0,0,0) → all four outputs 4096. `out_valid` rises exactly 5 clocks after the handshake.
- Single k1 basis: X=(0,16384,0,0) → outputs (7568, 3134, −3134, −7568).
- Round-trip: X=(4000,0,0,0), which is the DCT-II of a constant 1000 → outputs (1000,1000,1000,1000).
- Saturation:
  - X=(32767,32767,32767,32767) → out_sample0=32767 (clamped), out_sample1=−12260.
  - The negation of that X drives out_sample0 to −32768.
- Backpressure: hold `out_ready`=0 for 10 cycles with `in_valid`=1 and a new group applied → `out_valid` and samples held, `in_ready`=0, second group not taken. Raising `out_ready` completes the transfer, then the second group is accepted at the next IDLE cycle.
- Reset at E2 mid-MAC → next cycle `out_valid`=0, samples 0, `in_ready`=1. A following DC group yields clean 4096 outputs with no residue from the aborted group.
